packet_decoder_param: RTL

PACKET_DECODER_PARAM -- requirements
Module: packet_decoder_param

---
 rtl/packet_decoder_pkg.sv | 23 ++
 rtl/packet_decoder_if.sv | 51 +++++
 rtl/pkt_word_counter.sv | 46 ++++
 rtl/packet_decoder_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/packet_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packet_decoder_pkg
// Purpose  : Shared definitions for the packet decoder: FSM state encoding
//            and the default resync / start-of-packet patterns.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package packet_decoder_pkg;

    // Decoder FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Default framing patterns (32-bit; resized to WORD_W at the top level).
    localparam logic [31:0] c_resync_default = 32'h416F_DC1E;
    localparam logic [31:0] c_sop_default    = 32'hD78C_1B74;

endpackage : packet_decoder_pkg
`default_nettype wire

// File: rtl/packet_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : packet_decoder_if
// Purpose  : Word-stream input and decoded-output bundle of the packet
//            decoder. Signal directions are named from the decoder's side.
// Ports    : i_recv_word_cmd / i_recv_word_data       (source -> decoder)
//            o_start_data_payload, o_payload_data_word,
//            o_word_decode_complete, o_packet_done,
//            o_error, o_reset, o_words_remaining       (decoder -> sink)
// Modports : master (word source / observer), slave (decoder)
// Revision : 1.0 - initial release
// ============================================================================
interface packet_decoder_if #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
);
    logic              i_recv_word_cmd;
    logic [WORD_W-1:0] i_recv_word_data;
    logic              o_start_data_payload;
    logic [WORD_W-1:0] o_payload_data_word;
    logic              o_word_decode_complete;
    logic              o_packet_done;
    logic              o_error;
    logic              o_reset;
    logic [LEN_W-1:0]  o_words_remaining;

    modport master (
        output i_recv_word_cmd,
        output i_recv_word_data,
        input  o_start_data_payload,
        input  o_payload_data_word,
        input  o_word_decode_complete,
        input  o_packet_done,
        input  o_error,
        input  o_reset,
        input  o_words_remaining
    );

    modport slave (
        input  i_recv_word_cmd,
        input  i_recv_word_data,
        output o_start_data_payload,
        output o_payload_data_word,
        output o_word_decode_complete,
        output o_packet_done,
        output o_error,
        output o_reset,
        output o_words_remaining
    );
endinterface : packet_decoder_if
`default_nettype wire

// File: rtl/pkt_word_counter.sv
`default_nettype none
// ============================================================================
// Module   : pkt_word_counter
// Purpose  : Payload word counter. Loadable down-counter with last/zero flags.
// Ports    : i_clk, i_reset       clock, synchronous active-high reset
//            i_clear              synchronous clear to zero
//            i_load, i_load_val   load a new payload length
//            i_dec                decrement by one
//            o_count              current count (registered)
//            o_is_last            count == 1
//            o_zero               count == 0
// Priority : reset > clear > load > decrement
// Revision : 1.0 - initial release
// ============================================================================
module pkt_word_counter #(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [LEN_W-1:0] o_count,
    output logic             o_is_last,
    output logic             o_zero
);

    logic [LEN_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - LEN_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_is_last = (r_count == LEN_W'(1));
    assign o_zero    = (r_count == '0);

endmodule : pkt_word_counter
`default_nettype wire

// File: rtl/packet_decoder_param.sv
`default_nettype none
// ============================================================================
// Module   : packet_decoder_param
// Purpose  : Framed word-stream decoder. Waits for SOP_WORD, takes the next
//            word as payload length, then emits that many payload words.
//            RESYNC_WORD aborts from any state. All outputs are registered
//            (one-cycle latency from the input strobe).
// Ports    : i_clk    clock (rising edge)
//            i_reset  synchronous, active-high reset
//            bus      packet_decoder_if.slave (word input, decoded outputs)
// Config   : PACKET_DECODER_TIMEOUT_EN - when defined, an inter-word gap of
//            TIMEOUT_CYCLES in LEN/DATA raises o_error and returns to IDLE.
//            When undefined the decoder waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module packet_decoder_param
    import packet_decoder_pkg::*;
#(
    parameter int                WORD_W         = 32,
    parameter int                LEN_W          = 16,
    parameter int                MAX_LEN        = 1024,
    parameter logic [WORD_W-1:0] RESYNC_WORD    = WORD_W'(c_resync_default),
    parameter logic [WORD_W-1:0] SOP_WORD       = WORD_W'(c_sop_default),
    parameter int                TIMEOUT_CYCLES = 65535
) (
    input  logic            i_clk,
    input  logic            i_reset,
    packet_decoder_if.slave bus
);

    state_t            r_state;
    logic              r_start;
    logic [WORD_W-1:0] r_payload;
    logic              r_complete;
    logic              r_done;
    logic              r_error;
    logic              r_resync;

    logic              w_cmd;
    logic [WORD_W-1:0] w_data;
    logic [LEN_W-1:0]  w_len;
    logic              w_is_resync;
    logic              w_len_ok;
    logic              w_timeout;
    logic              w_cnt_clear;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic [LEN_W-1:0]  w_count;
    logic              w_cnt_last;
    logic              w_cnt_zero;

    assign w_cmd       = bus.i_recv_word_cmd;
    assign w_data      = bus.i_recv_word_data;
    assign w_len       = w_data[LEN_W-1:0];
    assign w_is_resync = w_cmd && (w_data == RESYNC_WORD);
    // 64-bit compare so MAX_LEN beyond the LEN_W range is handled correctly.
    assign w_len_ok    = (w_len != '0) && (64'(w_len) <= 64'(MAX_LEN));

`ifdef PACKET_DECODER_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] r_gap;

    // r_gap counts silent cycles already elapsed; the cycle that would make
    // it reach TIMEOUT_CYCLES is the timeout cycle.
    assign w_timeout = !w_cmd && (r_state != ST_IDLE) &&
                       (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || w_cmd || (r_state == ST_IDLE) || w_timeout) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Counter control mirrors the FSM decisions below.
    always_comb begin
        w_cnt_clear = w_is_resync || w_timeout;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        if (w_cmd && !w_is_resync) begin
            w_cnt_load = (r_state == ST_LEN) && w_len_ok;
            w_cnt_dec  = (r_state == ST_DATA) && !w_cnt_zero;
        end
    end

    pkt_word_counter #(
        .LEN_W      (LEN_W)
    ) u_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_cnt_clear),
        .i_load     (w_cnt_load),
        .i_load_val (w_len),
        .i_dec      (w_cnt_dec),
        .o_count    (w_count),
        .o_is_last  (w_cnt_last),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_start    <= 1'b0;
            r_payload  <= '0;
            r_complete <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_resync   <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_payload  <= '0;
            r_complete <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_resync   <= 1'b0;

            if (w_is_resync) begin
                r_resync <= 1'b1;
                r_state  <= ST_IDLE;
            end else if (w_timeout) begin
                r_error <= 1'b1;
                r_state <= ST_IDLE;
            end else if (w_cmd) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_data == SOP_WORD) begin
                            r_state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (w_len_ok) begin
                            r_start <= 1'b1;
                            r_state <= ST_DATA;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        // A zero count in DATA is unreachable; recover to IDLE.
                        if (w_cnt_zero) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_payload  <= w_data;
                            r_complete <= 1'b1;
                            if (w_cnt_last) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_start_data_payload   = r_start;
    assign bus.o_payload_data_word    = r_payload;
    assign bus.o_word_decode_complete = r_complete;
    assign bus.o_packet_done          = r_done;
    assign bus.o_error                = r_error;
    assign bus.o_reset                = r_resync;
    assign bus.o_words_remaining      = w_count;

endmodule : packet_decoder_param
`default_nettype wire
